// File: rtl/branch_pred_pkg.sv
// Shared types, encodings and helper functions for the BTB branch predictor.
package branch_pred_pkg;

    localparam int BP_ADDR_WIDTH = 64;
    localparam int BP_TAG_W      = BP_ADDR_WIDTH - 3;
    localparam int WAY_W         = 2;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } ctr_e;

    // Tag is stored zero-extended so the entry layout is independent of SET_COUNT.
    typedef struct packed {
        logic                     valid;
        logic [BP_TAG_W-1:0]      tag;
        logic [BP_ADDR_WIDTH-1:0] target;
        ctr_e                     counter;
    } btb_entry_t;

    localparam btb_entry_t BTB_ENTRY_RST = '{
        valid:   1'b0,
        tag:     {BP_TAG_W{1'b0}},
        target:  {BP_ADDR_WIDTH{1'b0}},
        counter: CNT_WNT
    };

    function automatic ctr_e ctr_train(input ctr_e cur, input logic taken);
        ctr_e nxt;
        case (cur)
            CNT_SNT: nxt = taken ? CNT_WNT : CNT_SNT;
            CNT_WNT: nxt = taken ? CNT_WT  : CNT_SNT;
            CNT_WT:  nxt = taken ? CNT_ST  : CNT_WNT;
            CNT_ST:  nxt = taken ? CNT_ST  : CNT_WT;
            default: nxt = CNT_WNT;
        endcase
        return nxt;
    endfunction

    function automatic logic [WAY_W-1:0] lowest_way(input logic [3:0] vec);
        logic [WAY_W-1:0] w;
        casez (vec)
            4'b???1: w = 2'd0;
            4'b??10: w = 2'd1;
            4'b?100: w = 2'd2;
            4'b1000: w = 2'd3;
            default: w = 2'd0;
        endcase
        return w;
    endfunction

    // Tree PLRU: bits[0] picks the half, bits[1] ways 0/1, bits[2] ways 2/3.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [2:0] bits);
        logic [WAY_W-1:0] v;
        if (bits[0]) begin
            v = {1'b1, bits[2]};
        end else begin
            v = {1'b0, bits[1]};
        end
        return v;
    endfunction

    function automatic logic [2:0] plru_touch(input logic [2:0] bits, input logic [WAY_W-1:0] way);
        logic [2:0] nxt;
        nxt = bits;
        if (way[1]) begin
            nxt[0] = 1'b0;
            nxt[2] = ~way[0];
        end else begin
            nxt[0] = 1'b1;
            nxt[1] = ~way[0];
        end
        return nxt;
    endfunction

endpackage

// File: rtl/btb_repl_policy.sv
// Per-set BTB replacement state: victim select for lookup, touch/advance on training.
// BTB_PLRU_EN selects tree pseudo-LRU; otherwise a per-set round-robin pointer.
module btb_repl_policy
    import branch_pred_pkg::*;
#(
    parameter  int SET_COUNT = 16,
    localparam int INDEX_W   = $clog2(SET_COUNT)
) (
    input  logic               i_clk,
    input  logic               i_arst_n,
    input  logic [INDEX_W-1:0] i_lookup_idx,
    output logic [WAY_W-1:0]   o_victim_way,
    input  logic               i_touch_en,
    input  logic               i_alloc_en,
    input  logic [INDEX_W-1:0] i_touch_idx,
    input  logic [WAY_W-1:0]   i_touch_way
);

`ifdef BTB_PLRU_EN
    logic [2:0] plru_r [SET_COUNT];
    logic       unused_alloc_s;

    assign unused_alloc_s = i_alloc_en;

    // Tree bits point away from the most recently trained way of each set
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int s = 0; s < SET_COUNT; s++) begin
                plru_r[s] <= 3'b000;
            end
        end else if (i_touch_en) begin
            plru_r[i_touch_idx] <= plru_touch(plru_r[i_touch_idx], i_touch_way);
        end
    end

    // Victim for the set currently being fetched
    always_comb begin
        o_victim_way = plru_victim(plru_r[i_lookup_idx]);
    end
`else
    logic [WAY_W-1:0] rr_r [SET_COUNT];
    logic             unused_touch_s;

    assign unused_touch_s = ^{i_touch_en, i_touch_way};

    // Pointer moves only on allocation; hit-training leaves it alone
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int s = 0; s < SET_COUNT; s++) begin
                rr_r[s] <= 2'd0;
            end
        end else if (i_alloc_en) begin
            rr_r[i_touch_idx] <= rr_r[i_touch_idx] + 2'd1;
        end
    end

    // Victim for the set currently being fetched
    always_comb begin
        o_victim_way = rr_r[i_lookup_idx];
    end
`endif

endmodule

// File: rtl/branch_pred_unit.sv
// Fetch-side branch predictor: 4-way set-associative BTB with 2-bit counters, trained from execute.
// Optional macro BTB_PLRU_EN switches victim selection from round-robin to tree pseudo-LRU.
module branch_pred_unit
    import branch_pred_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int SET_COUNT  = 16,
    parameter int WAY_COUNT  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic [ADDR_WIDTH-1:0] i_pc_fetch,
    output logic                  o_branch_pred_taken,
    output logic [ADDR_WIDTH-1:0] o_pc_target_pred,
    output logic [1:0]            o_btb_way,
    input  logic                  i_stall_exec,
    input  logic                  i_branch_exec,
    input  logic                  i_branch_taken_exec,
    input  logic [ADDR_WIDTH-1:0] i_pc_exec,
    input  logic [ADDR_WIDTH-1:0] i_pc_target_exec,
    input  logic [1:0]            i_btb_way_exec
);

    localparam int INDEX_W = $clog2(SET_COUNT);

    btb_entry_t btb_r [SET_COUNT][WAY_COUNT];

    logic [INDEX_W-1:0]   f_idx_s;
    logic [BP_TAG_W-1:0]  f_tag_s;
    logic [WAY_COUNT-1:0] f_valid_vec_s;
    logic [WAY_COUNT-1:0] f_hit_vec_s;
    logic                 f_hit_s;
    logic                 f_has_free_s;
    logic [WAY_W-1:0]     f_hit_way_s;
    logic [WAY_W-1:0]     f_free_way_s;
    logic [WAY_W-1:0]     repl_victim_s;

    logic                 upd_en_s;
    logic [INDEX_W-1:0]   e_idx_s;
    logic [BP_TAG_W-1:0]  e_tag_s;
    btb_entry_t           e_cur_s;
    btb_entry_t           e_new_s;
    logic                 e_hit_s;
    logic                 e_write_s;
    logic                 e_alloc_s;

    logic                 unused_pc_bits_s;

    assign unused_pc_bits_s = ^{i_pc_fetch[1:0], i_pc_exec[1:0]};

    // Fetch-side tag compare against the registered set; no bypass of same-cycle training
    always_comb begin
        f_idx_s = i_pc_fetch[INDEX_W+1:2];
        f_tag_s = BP_TAG_W'(i_pc_fetch[ADDR_WIDTH-1:INDEX_W+2]);
        for (int w = 0; w < WAY_COUNT; w++) begin
            f_valid_vec_s[w] = btb_r[f_idx_s][w].valid;
            f_hit_vec_s[w]   = btb_r[f_idx_s][w].valid && (btb_r[f_idx_s][w].tag == f_tag_s);
        end
        f_hit_s      = |f_hit_vec_s;
        f_has_free_s = ~&f_valid_vec_s;
        f_hit_way_s  = lowest_way(f_hit_vec_s);
        f_free_way_s = lowest_way(~f_valid_vec_s);
    end

    // Prediction outputs; on a miss the way output nominates the allocation slot
    always_comb begin
        if (f_hit_s) begin
            o_branch_pred_taken = btb_r[f_idx_s][f_hit_way_s].counter[1];
            o_pc_target_pred    = ADDR_WIDTH'(btb_r[f_idx_s][f_hit_way_s].target);
            o_btb_way           = f_hit_way_s;
        end else begin
            o_branch_pred_taken = 1'b0;
            o_pc_target_pred    = {ADDR_WIDTH{1'b0}};
            o_btb_way           = f_has_free_s ? f_free_way_s : repl_victim_s;
        end
    end

    // Training decision for the way carried down from fetch
    always_comb begin
        upd_en_s  = i_branch_exec & ~i_stall_exec;
        e_idx_s   = i_pc_exec[INDEX_W+1:2];
        e_tag_s   = BP_TAG_W'(i_pc_exec[ADDR_WIDTH-1:INDEX_W+2]);
        e_cur_s   = btb_r[e_idx_s][i_btb_way_exec];
        e_hit_s   = e_cur_s.valid && (e_cur_s.tag == e_tag_s);
        e_new_s   = e_cur_s;
        e_write_s = 1'b0;
        e_alloc_s = 1'b0;
        if (upd_en_s && e_hit_s) begin
            e_write_s       = 1'b1;
            e_new_s.counter = ctr_train(e_cur_s.counter, i_branch_taken_exec);
            if (i_branch_taken_exec) begin
                e_new_s.target = BP_ADDR_WIDTH'(i_pc_target_exec);
            end else begin
                e_new_s.target = e_cur_s.target;
            end
        end else if (upd_en_s && i_branch_taken_exec) begin
            e_write_s       = 1'b1;
            e_alloc_s       = 1'b1;
            e_new_s.valid   = 1'b1;
            e_new_s.tag     = e_tag_s;
            e_new_s.target  = BP_ADDR_WIDTH'(i_pc_target_exec);
            e_new_s.counter = CNT_WT;
        end else begin
            e_write_s = 1'b0;
            e_alloc_s = 1'b0;
        end
    end

    // BTB storage: async clear, single write port driven by execute
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int s = 0; s < SET_COUNT; s++) begin
                for (int w = 0; w < WAY_COUNT; w++) begin
                    btb_r[s][w] <= BTB_ENTRY_RST;
                end
            end
        end else if (e_write_s) begin
            btb_r[e_idx_s][i_btb_way_exec] <= e_new_s;
        end
    end

    btb_repl_policy #(
        .SET_COUNT(SET_COUNT)
    ) u_repl (
        .i_clk        (i_clk),
        .i_arst_n     (i_arst_n),
        .i_lookup_idx (f_idx_s),
        .o_victim_way (repl_victim_s),
        .i_touch_en   (e_write_s),
        .i_alloc_en   (e_alloc_s),
        .i_touch_idx  (e_idx_s),
        .i_touch_way  (i_btb_way_exec)
    );

endmodule

// File: tb/tb_branch_pred_unit.sv
// Self-checking bench for branch_pred_unit: directed scenarios then randomized traffic vs a reference model.
module tb_branch_pred_unit;

    localparam int SETS = 16;
    localparam int IW   = 4;
`ifdef BTB_PLRU_EN
    localparam logic [1:0] AFTER_EVICT_WAY = 2'd2;
`else
    localparam logic [1:0] AFTER_EVICT_WAY = 2'd1;
`endif

    logic        clk;
    logic        rst_n;
    logic [63:0] pc_fetch;
    logic        pred_taken;
    logic [63:0] target_pred;
    logic [1:0]  btb_way;
    logic        stall_exec;
    logic        branch_exec;
    logic        taken_exec;
    logic [63:0] pc_exec;
    logic [63:0] target_exec;
    logic [1:0]  way_exec;

    int total;
    int passed;
    int failed;

    branch_pred_unit #(.ADDR_WIDTH(64), .SET_COUNT(SETS), .WAY_COUNT(4)) dut (
        .i_clk               (clk),
        .i_arst_n            (rst_n),
        .i_pc_fetch          (pc_fetch),
        .o_branch_pred_taken (pred_taken),
        .o_pc_target_pred    (target_pred),
        .o_btb_way           (btb_way),
        .i_stall_exec        (stall_exec),
        .i_branch_exec       (branch_exec),
        .i_branch_taken_exec (taken_exec),
        .i_pc_exec           (pc_exec),
        .i_pc_target_exec    (target_exec),
        .i_btb_way_exec      (way_exec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain per-set arrays, counters as integers 0..3
    bit          m_valid [SETS][4];
    logic [63:0] m_tag   [SETS][4];
    logic [63:0] m_tgt   [SETS][4];
    int          m_ctr   [SETS][4];
    int          m_allocs [SETS];
    int          m_last_half [SETS];
    int          m_last_in_pair [SETS][2];

    function automatic int set_of(input logic [63:0] pc);
        return int'((pc >> 2) % 64'(SETS));
    endfunction

    function automatic logic [63:0] tag_of(input logic [63:0] pc);
        return pc >> (IW + 2);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < 4; w++) begin
                m_valid[s][w] = 1'b0;
                m_tag[s][w]   = 64'd0;
                m_tgt[s][w]   = 64'd0;
                m_ctr[s][w]   = 1;
            end
            m_allocs[s]          = 0;
            m_last_half[s]       = 1;
            m_last_in_pair[s][0] = 1;
            m_last_in_pair[s][1] = 1;
        end
    endtask

    function automatic int model_victim(input int s);
`ifdef BTB_PLRU_EN
        int h;
        h = 1 - m_last_half[s];
        return h * 2 + (1 - m_last_in_pair[s][h]);
`else
        return m_allocs[s] % 4;
`endif
    endfunction

    task automatic model_touch(input int s, input int w);
        m_last_half[s] = w / 2;
        m_last_in_pair[s][w / 2] = w % 2;
    endtask

    task automatic model_lookup(input logic [63:0] pc, output logic t, output logic [63:0] tg, output int way);
        int s;
        s = set_of(pc);
        way = -1;
        for (int w = 0; w < 4; w++) begin
            if (way < 0 && m_valid[s][w] && m_tag[s][w] == tag_of(pc)) way = w;
        end
        if (way >= 0) begin
            t  = (m_ctr[s][way] >= 2);
            tg = m_tgt[s][way];
        end else begin
            t  = 1'b0;
            tg = 64'd0;
            for (int w = 0; w < 4; w++) begin
                if (way < 0 && !m_valid[s][w]) way = w;
            end
            if (way < 0) way = model_victim(s);
        end
    endtask

    task automatic model_update(input logic [63:0] pc, input logic tk, input logic [63:0] tgt, input int w);
        int s;
        s = set_of(pc);
        if (m_valid[s][w] && m_tag[s][w] == tag_of(pc)) begin
            if (tk) begin
                m_ctr[s][w] = (m_ctr[s][w] == 3) ? 3 : m_ctr[s][w] + 1;
                m_tgt[s][w] = tgt;
            end else begin
                m_ctr[s][w] = (m_ctr[s][w] == 0) ? 0 : m_ctr[s][w] - 1;
            end
            model_touch(s, w);
        end else if (tk) begin
            m_valid[s][w] = 1'b1;
            m_tag[s][w]   = tag_of(pc);
            m_tgt[s][w]   = tgt;
            m_ctr[s][w]   = 2;
            m_allocs[s]++;
            model_touch(s, w);
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_exec();
        branch_exec = 1'b0;
        taken_exec  = 1'b0;
        stall_exec  = 1'b0;
        pc_exec     = 64'd0;
        target_exec = 64'd0;
        way_exec    = 2'd0;
    endtask

    task automatic set_exec(input logic tk, input logic [63:0] pc, input logic [63:0] tgt,
                            input logic [1:0] w, input logic st);
        branch_exec = 1'b1;
        taken_exec  = tk;
        pc_exec     = pc;
        target_exec = tgt;
        way_exec    = w;
        stall_exec  = st;
    endtask

    // Called at a falling edge; checks lookup, lets one rising edge pass, returns at the next falling edge
    task automatic look(input string tag, input logic [63:0] pc, input logic et,
                        input logic [63:0] etgt, input logic [1:0] eway);
        pc_fetch = pc;
        #1;
        chk({tag, "_taken"}, 64'(pred_taken), 64'(et));
        chk({tag, "_target"}, target_pred, etgt);
        chk({tag, "_way"}, 64'(btb_way), 64'(eway));
        @(negedge clk);
        idle_exec();
    endtask

    logic [63:0] pool [12];
    logic [63:0] fpc, epc, etg, m_tg, d_tg;
    logic        ebr, etk, est, m_t, d_t;
    int          ew, m_w;

    initial begin
        total = 0; passed = 0; failed = 0;
        rst_n = 1'b0;
        pc_fetch = 64'h1000;
        idle_exec();
        #1;
        chk("reset_taken", 64'(pred_taken), 64'd0);
        chk("reset_target", target_pred, 64'd0);
        chk("reset_way", 64'(btb_way), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Allocation and counter training on PC 0x1000
        set_exec(1'b1, 64'h1000, 64'h2000, 2'd0, 1'b0);
        look("miss_1000", 64'h1000, 1'b0, 64'h0, 2'd0);
        look("alloc_1000", 64'h1000, 1'b1, 64'h2000, 2'd0);
        set_exec(1'b0, 64'h1000, 64'h0, 2'd0, 1'b0);
        look("ctr_wt", 64'h1000, 1'b1, 64'h2000, 2'd0);
        set_exec(1'b0, 64'h1000, 64'h0, 2'd0, 1'b0);
        look("ctr_wnt", 64'h1000, 1'b0, 64'h2000, 2'd0);
        set_exec(1'b0, 64'h1000, 64'h0, 2'd0, 1'b0);
        look("ctr_snt", 64'h1000, 1'b0, 64'h2000, 2'd0);
        set_exec(1'b1, 64'h1000, 64'h2000, 2'd0, 1'b0);
        look("ctr_snt_sat", 64'h1000, 1'b0, 64'h2000, 2'd0);
        set_exec(1'b1, 64'h1000, 64'h2000, 2'd0, 1'b0);
        look("ctr_wnt_up", 64'h1000, 1'b0, 64'h2000, 2'd0);
        look("ctr_wt_up", 64'h1000, 1'b1, 64'h2000, 2'd0);

        // Not-taken miss must not allocate
        set_exec(1'b0, 64'h3000, 64'h1234, 2'd0, 1'b0);
        look("nt_miss_pre", 64'h3000, 1'b0, 64'h0, 2'd1);
        look("nt_miss_post", 64'h3000, 1'b0, 64'h0, 2'd1);
        look("nt_keep_1000", 64'h1000, 1'b1, 64'h2000, 2'd0);

        // Fill set 0 and evict with a fifth tag
        set_exec(1'b1, 64'h1040, 64'h5040, 2'd1, 1'b0);
        look("fill_1040", 64'h1040, 1'b0, 64'h0, 2'd1);
        set_exec(1'b1, 64'h1080, 64'h5080, 2'd2, 1'b0);
        look("fill_1080", 64'h1080, 1'b0, 64'h0, 2'd2);
        set_exec(1'b1, 64'h10C0, 64'h50C0, 2'd3, 1'b0);
        look("fill_10c0", 64'h10C0, 1'b0, 64'h0, 2'd3);
        set_exec(1'b1, 64'h1100, 64'h6100, 2'd0, 1'b0);
        look("victim_1100", 64'h1100, 1'b0, 64'h0, 2'd0);
        look("evicted_1000", 64'h1000, 1'b0, 64'h0, AFTER_EVICT_WAY);
        look("hit_1040", 64'h1042, 1'b1, 64'h5040, 2'd1);
        look("hit_1080", 64'h1080, 1'b1, 64'h5080, 2'd2);
        look("hit_10c0", 64'h10C3, 1'b1, 64'h50C0, 2'd3);
        look("hit_1100", 64'h1100, 1'b1, 64'h6100, 2'd0);

        // Stalled update leaves the table alone
        set_exec(1'b1, 64'h1040, 64'h7777, 2'd1, 1'b1);
        look("stall_pre", 64'h1040, 1'b1, 64'h5040, 2'd1);
        look("stall_post", 64'h1040, 1'b1, 64'h5040, 2'd1);

        // Same-cycle lookup sees the old entry, next cycle the new one
        set_exec(1'b1, 64'h1040, 64'h8040, 2'd1, 1'b0);
        look("same_cyc_old", 64'h1040, 1'b1, 64'h5040, 2'd1);
        look("same_cyc_new", 64'h1040, 1'b1, 64'h8040, 2'd1);

        // Reset mid-run with a training update pending
        set_exec(1'b1, 64'h1080, 64'h9999, 2'd2, 1'b0);
        pc_fetch = 64'h1080;
        #1;
        chk("prerst_taken", 64'(pred_taken), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_taken", 64'(pred_taken), 64'd0);
        chk("midrst_target", target_pred, 64'd0);
        chk("midrst_way", 64'(btb_way), 64'd0);
        @(negedge clk);
        idle_exec();
        rst_n = 1'b1;
        look("postrst_1080", 64'h1080, 1'b0, 64'h0, 2'd0);
        look("postrst_1100", 64'h1100, 1'b0, 64'h0, 2'd0);

        // Randomized traffic against the reference model, two hot sets with six tags each
        model_reset();
        for (int k = 0; k < 12; k++) begin
            pool[k] = ({$urandom, $urandom} << (IW + 2)) | 64'(((k < 6) ? 3 : 9) << 2);
        end
        for (int i = 0; i < 400; i++) begin
            fpc = pool[$urandom_range(11, 0)] | 64'($urandom_range(3, 0));
            epc = pool[$urandom_range(11, 0)];
            model_lookup(epc, m_t, m_tg, ew);
            ebr = ($urandom_range(9, 0) < 7);
            etk = 1'($urandom_range(1, 0));
            est = ($urandom_range(4, 0) == 0);
            etg = {$urandom, $urandom};
            branch_exec = ebr;
            taken_exec  = etk;
            stall_exec  = est;
            pc_exec     = epc;
            target_exec = etg;
            way_exec    = 2'(ew);
            pc_fetch    = fpc;
            #1;
            model_lookup(fpc, d_t, d_tg, m_w);
            chk($sformatf("rnd%0d_taken", i), 64'(pred_taken), 64'(d_t));
            chk($sformatf("rnd%0d_target", i), target_pred, d_tg);
            chk($sformatf("rnd%0d_way", i), 64'(btb_way), 64'(m_w));
            @(posedge clk);
            if (ebr && !est) model_update(epc, etk, etg, ew);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
